// File: rtl/disp_digit_writer_pkg.sv
// Shared definitions for the digit display writer: write-port polarity,
// display buffer geometry, default blank code and the writer FSM encoding.
package disp_digit_writer_pkg;

   // Write-port strobes are active low.
   localparam logic EN_ACT  = 1'b0;
   localparam logic EN_IDLE = 1'b1;

   // Display buffer geometry.
   localparam int ADR_W = 7;
   localparam int DIG_W = 4;

   // Digit code used for blanked leading zeros.
   localparam logic [DIG_W-1:0] BLANK_CODE_DEF = 4'hF;

   // Writer FSM states.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONV    = 3'd1,
      S_WAIT_VS = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } wr_state_e;

endpackage

// File: rtl/disp_digit_writer_bin2bcd_iter.sv
// Iterative double-dabble binary to BCD converter.
// start_i loads the value and clears the BCD accumulator; the next VAL_W
// cycles each perform one add-3/shift step. done_o is high during the final
// step, and bcd_o shows the value the accumulator takes at the next edge,
// so the final result is visible in the same cycle as done_o and is held
// afterwards.
module bin2bcd_iter #(
   parameter int VAL_W   = 20,
   parameter int BCD_DIG = 7
) (
   input  logic                   disp_clk,
   input  logic                   rst_disp_n,
   input  logic                   start_i,
   input  logic [VAL_W-1:0]       value_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*BCD_DIG-1:0]   bcd_o
);

   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [4*BCD_DIG-1:0] bcd_q, bcd_d, adj;
   logic [VAL_W-1:0]     sh_q, sh_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;

   // One double-dabble step per cycle while busy; start reloads everything.
   always_comb begin
      adj    = bcd_q;
      bcd_d  = bcd_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_o = 1'b0;
      for (int i = 0; i < BCD_DIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      if (start_i) begin
         bcd_d  = '0;
         sh_d   = value_i;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = {adj[4*BCD_DIG-2:0], sh_q[VAL_W-1]};
         sh_d  = {sh_q[VAL_W-2:0], 1'b0};
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(VAL_W - 1)) begin
            busy_d = 1'b0;
            done_o = 1'b1;
         end
      end
   end

   // Converter state registers.
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         bcd_q  <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign bcd_o  = bcd_d;

endmodule

// File: rtl/disp_digit_writer.sv
// Digit display writer: converts a binary value to BCD and streams one
// write per digit (most significant first) into consecutive display buffer
// addresses, with optional leading-zero blanking and saturation to all 9s.
//
// Handshake: i_req is sampled only in IDLE; the cycle it is seen high is the
// accept cycle. o_busy is high from the next cycle up to and including the
// o_done pulse; requests while busy are dropped. Every output is a register
// loaded from the next-state decode, so the outputs line up with the state.
module disp_digit_writer
   import disp_digit_writer_pkg::*;
#(
   parameter int         VAL_W      = 20,
   parameter int         BCD_DIG    = 7,
   parameter int         MAX_DISP   = 128,
   parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
   parameter bit         SYNC_TO_VS = 1'b1
) (
   input  logic             disp_clk,
   input  logic             rst_disp_n,
   input  logic             i_sync_vs,
   input  logic             i_req,
   input  logic [VAL_W-1:0] i_value,
   input  logic [6:0]       i_base_adr,
   input  logic [3:0]       i_num_dig,
   input  logic             i_lz_blank,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_disp_wen,
   output logic             o_disp_men,
   output logic [6:0]       o_disp_adr,
   output logic [3:0]       o_disp_d
);

   wr_state_e            state_q, state_d;
   logic [3:0]           k_q, k_d;
   logic [ADR_W-1:0]     base_q;
   logic [3:0]           n_q;
   logic                 lz_q;
   logic                 vs_q;

   logic                 conv_start, conv_busy, conv_done;
   logic [4*BCD_DIG-1:0] bcd;
   logic                 vs_fall;
   logic [3:0]           n_clamp;

   logic [3:0]           pos, nib, msd, code;
   logic                 sat;
   logic [ADR_W:0]       adr_sum;
   logic                 adr_ok;

   logic                 busy_q, done_q, wen_q, men_q;
   logic [ADR_W-1:0]     adr_q;
   logic [DIG_W-1:0]     dig_q;

   assign conv_start = (state_q == S_IDLE) && i_req;
   assign vs_fall    = vs_q && !i_sync_vs;

   bin2bcd_iter #(
      .VAL_W   (VAL_W),
      .BCD_DIG (BCD_DIG)
   ) u_bin2bcd (
      .disp_clk   (disp_clk),
      .rst_disp_n (rst_disp_n),
      .start_i    (conv_start),
      .value_i    (i_value),
      .busy_o     (conv_busy),
      .done_o     (conv_done),
      .bcd_o      (bcd)
   );

   // Clamp the requested digit count into 1..BCD_DIG.
   always_comb begin
      if (i_num_dig == 4'd0) begin
         n_clamp = 4'd1;
      end else if (i_num_dig > 4'(BCD_DIG)) begin
         n_clamp = 4'(BCD_DIG);
      end else begin
         n_clamp = i_num_dig;
      end
   end

   // Next-state and digit index.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_req) state_d = S_CONV;
         end
         S_CONV: begin
            if (conv_done) begin
               state_d = SYNC_TO_VS ? S_WAIT_VS : S_WRITE;
               k_d     = '0;
            end else if (!conv_busy) begin
               // Converter lost its run (cannot happen in normal operation).
               state_d = S_IDLE;
            end
         end
         S_WAIT_VS: begin
            if (vs_fall) begin
               state_d = S_WRITE;
               k_d     = '0;
            end
         end
         S_WRITE: begin
            if (k_q == n_q - 4'd1) begin
               state_d = S_DONE;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Digit code and address for the write issued in the next cycle (index k_d).
   // The BCD view is the converter's next value, so the first write can
   // leave straight out of the last conversion step.
   always_comb begin
      sat = 1'b0;
      msd = '0;
      nib = '0;
      pos = n_q - 4'd1 - k_d;
      for (int i = 0; i < BCD_DIG; i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            msd = 4'(i);
            if (4'(i) >= n_q) sat = 1'b1;
         end
         if (4'(i) == pos) nib = bcd[4*i +: 4];
      end
      if (sat) begin
         code = 4'd9;
      end else if (lz_q && (pos > msd)) begin
         code = BLANK_CODE;
      end else begin
         code = nib;
      end
      // The address wraps mod 128, but a run that walks past the end of the
      // buffer is suppressed: validity is judged on the unwrapped sum.
      adr_sum = {1'b0, base_q} + {4'd0, k_d};
      adr_ok  = ({24'd0, adr_sum} < 32'(MAX_DISP));
   end

   // FSM state, digit index and request parameters latched at accept.
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         base_q  <= '0;
         n_q     <= 4'd1;
         lz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (conv_start) begin
            base_q <= i_base_adr;
            n_q    <= n_clamp;
            lz_q   <= i_lz_blank;
         end
      end
   end

   // Vertical sync history for falling-edge detection.
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         vs_q <= 1'b0;
      end else begin
         vs_q <= i_sync_vs;
      end
   end

   // Registered outputs; address and data hold outside WRITE.
   always_ff @(posedge disp_clk or negedge rst_disp_n) begin
      if (!rst_disp_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         wen_q  <= EN_IDLE;
         men_q  <= EN_IDLE;
         adr_q  <= '0;
         dig_q  <= '0;
      end else begin
         busy_q <= (state_d != S_IDLE);
         done_q <= (state_d == S_DONE);
         if (state_d == S_WRITE) begin
            adr_q <= adr_sum[ADR_W-1:0];
            dig_q <= code;
            wen_q <= adr_ok ? EN_ACT : EN_IDLE;
            men_q <= adr_ok ? EN_ACT : EN_IDLE;
         end else begin
            wen_q <= EN_IDLE;
            men_q <= EN_IDLE;
         end
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_disp_wen = wen_q;
   assign o_disp_men = men_q;
   assign o_disp_adr = adr_q;
   assign o_disp_d   = dig_q;

endmodule

// File: tb/tb_disp_digit_writer.sv
// Bench for disp_digit_writer: one instance without vsync alignment (dut0)
// and one with it (dut1). Writes are recorded as {cycle offset, adr, digit}
// relative to the cycle after accept and compared against an expected queue
// built from table entries or from a decimal-arithmetic reference model.
module tb_disp_digit_writer;

   logic        clk = 1'b0;
   logic        rst_disp_n = 1'b1;
   logic        vs = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [19:0] value = '0;
   logic [6:0]  base = '0;
   logic [3:0]  num = '0;
   logic        lz_blank = 1'b0;

   logic       busy0, done0, wen0, men0, busy1, done1, wen1, men1;
   logic [6:0] adr0, adr1;
   logic [3:0] d0, d1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [18:0] exp_q[$];
   logic [18:0] obs_q[$];

   typedef struct {
      int          value;
      int          base;
      int          num;
      logic        lz;
      logic [27:0] dig;   // expected digits, first written digit leftmost
      int          n;     // effective digit count (write cycles)
   } vec_t;

   vec_t vecs[12];

   // Clock
   always #5 clk = ~clk;

   disp_digit_writer #(.SYNC_TO_VS(1'b0)) dut0 (
      .disp_clk(clk), .rst_disp_n(rst_disp_n), .i_sync_vs(vs), .i_req(req0),
      .i_value(value), .i_base_adr(base), .i_num_dig(num), .i_lz_blank(lz_blank),
      .o_busy(busy0), .o_done(done0), .o_disp_wen(wen0), .o_disp_men(men0),
      .o_disp_adr(adr0), .o_disp_d(d0)
   );

   disp_digit_writer #(.SYNC_TO_VS(1'b1)) dut1 (
      .disp_clk(clk), .rst_disp_n(rst_disp_n), .i_sync_vs(vs), .i_req(req1),
      .i_value(value), .i_base_adr(base), .i_num_dig(num), .i_lz_blank(lz_blank),
      .o_busy(busy1), .o_done(done1), .o_disp_wen(wen1), .o_disp_men(men1),
      .o_disp_adr(adr1), .o_disp_d(d1)
   );

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic int clamp_n(input int nd);
      if (nd == 0) return 1;
      if (nd > 7) return 7;
      return nd;
   endfunction

   // Reference: digit shown at decimal position pos of an n-digit field.
   function automatic logic [3:0] model_digit(input int v, input int n, input int pos, input logic lz);
      if (v >= pow10(n)) return 4'd9;
      if (lz && pos > 0 && v < pow10(pos)) return 4'hF;
      return 4'((v / pow10(pos)) % 10);
   endfunction

   task automatic push_exp(input int first_off, input int v, input int b, input int n,
                           input logic lz, input logic [27:0] tbl, input bit use_tbl);
      for (int k = 0; k < n; k++) begin
         int         adr;
         logic [3:0] dig;
         adr = b + k;
         dig = use_tbl ? tbl[4*(n-1-k) +: 4] : model_digit(v, n, n - 1 - k, lz);
         if (adr < 128) exp_q.push_back({8'(first_off + k), 7'(adr), dig});
      end
   endtask

   task automatic compare_writes(input string tag);
      logic [18:0] e, o;
      check({tag, " write count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check({tag, " write {off,adr,dig}"}, int'(o), int'(e));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   // One burst on dut0; inputs are scrambled after accept to prove latching.
   task automatic burst0(input string tag, input int v, input int b, input int nd,
                         input logic lz, input int n);
      int off, done_off, done_n, busy_n, stb_err;
      done_off = -10; done_n = 0; busy_n = 0; stb_err = 0;
      obs_q.delete();
      @(negedge clk);
      value = 20'(v); base = 7'(b); num = 4'(nd); lz_blank = lz; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      value = 20'($urandom); base = 7'($urandom); num = 4'($urandom); lz_blank = 1'($urandom);
      off = 0;
      while (off < 200 && !(done_n > 0 && off > done_off + 1)) begin
         if (!wen0 || !men0) obs_q.push_back({8'(off), adr0, d0});
         if (wen0 != men0) stb_err++;
         if (busy0) busy_n++;
         if (done0) begin done_n++; done_off = off; end
         @(negedge clk);
         off++;
      end
      check({tag, " done pulses"}, done_n, 1);
      check({tag, " done offset"}, done_off, 20 + n);
      check({tag, " busy cycles"}, busy_n, 21 + n);
      check({tag, " wen/men agree"}, stb_err, 0);
      compare_writes(tag);
   endtask

   // One burst on dut1 (value 1234, base 10, 4 digits) with a scripted vsync.
   task automatic burst1(input string tag, input int fall_a, input int fall_b,
                         input int extra_req, input int first_off);
      int off, done_off, done_n, busy_n, stb_err;
      done_off = -100; done_n = 0; busy_n = 0; stb_err = 0;
      obs_q.delete();
      push_exp(first_off, 1234, 10, 4, 1'b0, 28'h0, 1'b0);
      @(negedge clk);
      value = 20'd1234; base = 7'd10; num = 4'd4; lz_blank = 1'b0; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      off = 0;
      while (off < 300 && !(done_n > 0 && off > done_off + 10)) begin
         if (!wen1 || !men1) obs_q.push_back({8'(off), adr1, d1});
         if (wen1 != men1) stb_err++;
         if (busy1) busy_n++;
         if (done1) begin done_n++; done_off = off; end
         vs   = !((off >= fall_a && off < fall_a + 3) || (off >= fall_b && off < fall_b + 3));
         req1 = (off == extra_req) || (off == extra_req + 40);
         @(negedge clk);
         off++;
      end
      vs = 1'b1; req1 = 1'b0;
      check({tag, " done pulses"}, done_n, 1);
      check({tag, " done offset"}, done_off, first_off + 4);
      check({tag, " busy cycles"}, busy_n, first_off + 5);
      check({tag, " wen/men agree"}, stb_err, 0);
      compare_writes(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " dut0 busy"}, 32'(busy0), 0);
      check({tag, " dut0 done"}, 32'(done0), 0);
      check({tag, " dut0 wen"},  32'(wen0), 1);
      check({tag, " dut0 men"},  32'(men0), 1);
      check({tag, " dut0 adr"},  32'(adr0), 0);
      check({tag, " dut0 d"},    32'(d0), 0);
      check({tag, " dut1 busy"}, 32'(busy1), 0);
      check({tag, " dut1 wen"},  32'(wen1), 1);
      check({tag, " dut1 men"},  32'(men1), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_strobe, n_done;

      vecs[0]  = '{1234,    10,  4, 1'b0, 28'h0001234, 4};
      vecs[1]  = '{7,       20,  4, 1'b1, 28'h000FFF7, 4};
      vecs[2]  = '{0,       20,  4, 1'b1, 28'h000FFF0, 4};
      vecs[3]  = '{123456,  30,  4, 1'b0, 28'h0009999, 4};
      vecs[4]  = '{1048575, 40,  7, 1'b0, 28'h1048575, 7};
      vecs[5]  = '{4321,    126, 4, 1'b0, 28'h0004321, 4};
      vecs[6]  = '{5,       0,   0, 1'b1, 28'h0000005, 1};
      vecs[7]  = '{42,      50, 15, 1'b1, 28'hFFFFF42, 7};
      vecs[8]  = '{123456,  60,  4, 1'b1, 28'h0009999, 4};
      vecs[9]  = '{0,       70,  3, 1'b0, 28'h0000000, 3};
      vecs[10] = '{999,     80,  3, 1'b1, 28'h0000999, 3};
      vecs[11] = '{1000,    90,  3, 1'b1, 28'h0000999, 3};

      // Reset
      #2 rst_disp_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_disp_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table vectors on the free-running instance
      for (int i = 0; i < 12; i++) begin
         push_exp(20, vecs[i].value, vecs[i].base, vecs[i].n, vecs[i].lz, vecs[i].dig, 1'b1);
         burst0($sformatf("vec%0d", i), vecs[i].value, vecs[i].base, vecs[i].num, vecs[i].lz, vecs[i].n);
      end

      // Random bursts against the reference model
      for (int i = 0; i < 40; i++) begin
         int   v, b, nd;
         logic lz;
         v  = int'($urandom_range(0, (1 << 20) - 1) >> $urandom_range(0, 19));
         b  = int'($urandom_range(0, 127));
         nd = int'($urandom_range(0, 15));
         lz = 1'($urandom_range(0, 1));
         push_exp(20, v, b, clamp_n(nd), lz, 28'h0, 1'b0);
         burst0($sformatf("rand%0d", i), v, b, nd, lz, clamp_n(nd));
      end

      // Vsync-aligned: edge 50 cycles after conversion, requests while busy
      burst1("vs_late", 70, -100, 30, 71);
      // Edge during the final conversion cycle is missed; next edge is used
      burst1("vs_missed", 19, 40, -100, 41);

      // Reset during the second write cycle
      @(negedge clk);
      value = 20'd1234; base = 7'd10; num = 4'd4; lz_blank = 1'b0; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      repeat (21) @(negedge clk);
      check("mid-burst strobe active", 32'(wen0), 0);
      check("mid-burst adr", 32'(adr0), 11);
      rst_disp_n = 1'b0;
      #1 check_reset_outputs("async reset");
      repeat (2) @(negedge clk);
      rst_disp_n = 1'b1;
      n_strobe = 0; n_done = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (!wen0 || !men0) n_strobe++;
         if (done0 || busy0) n_done++;
      end
      check("post-reset strobes", n_strobe, 0);
      check("post-reset done/busy", n_done, 0);
      push_exp(20, 1234, 10, 4, 1'b0, 28'h0, 1'b0);
      burst0("after reset", 1234, 10, 4, 1'b0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
